line_screen_mapper: RTL and testbench
=====================================

LINE_SCREEN_MAPPER -- requirements
Module: line_screen_mapper

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_l.
REQ-002 Port clk  input  1  system clock, shared with the vector generator and the rasterizer.
REQ-003 Port rst_l  input  1  asynchronous, active-low reset.
REQ-004 Port flush  input  1  synchronous discard of all in-flight lines, asserted on vector-generator restart.
REQ-005 Port in_valid  input  1  input line descriptor valid.
REQ-006 Port in_ready  output  1  block accepts the input line this cycle.
REQ-007 Port in_start_x, in_start_y, in_end_x, in_end_y  input  13 each  signed AVG-space endpoints.
REQ-008 Port in_intensity  input  4  line intensity.
REQ-009 Port out_valid  output  1  mapped line valid toward the rasterizer.
REQ-010 Port out_ready  input  1  rasterizer accepts the mapped line.
REQ-011 Port out_start_x, out_start_y, out_end_x, out_end_y  output  13 each  signed screen-space endpoints.
REQ-012 Port out_intensity  output  4  intensity passed through unchanged.
REQ-013 Port drop_count  output  16  saturating count of rejected lines.
REQ-014 Port busy  output  1  high when any pipeline stage holds a line.

Function
REQ-015 A transfer SHALL occur on a clk edge where valid and ready are both high, on each side independently.
REQ-016 X mapping SHALL be sx = floor(((x+512)*5)/8), computed on a 16-bit signed intermediate with an arithmetic shift.
REQ-017 Y mapping SHALL be sy = 479 - floor(((y+384)*5)/8), computed on a 16-bit signed intermediate.
REQ-018 Mapped results SHALL be truncated to 13-bit signed; the representable input range guarantees no overflow.
REQ-019 The block SHALL be a 2-stage pipeline: S1 registers the mapped coordinates, S2 is the output register.
REQ-020 Latency from input acceptance to out_valid SHALL be 2 cycles when there is no stall, with a throughput of 1 line per cycle.
REQ-021 A line SHALL be rejected at S1→S2 advance if any of the following holds:
- intensity==0;
- both sx<0;
- both sx>639;
- both sy<0;
- both sy>479.
REQ-022 A rejected line SHALL never assert out_valid.
REQ-023 Each rejected line SHALL increment drop_count by 1; drop_count SHALL saturate at 0xFFFF.
REQ-024 Partially visible lines SHALL pass unclipped; per-pixel suppression belongs to the rasterizer.
REQ-025 S2 SHALL load when S2 is empty or out_ready is high.
REQ-026 S1 SHALL advance when S1 is valid and (the S1 line is rejected or S2 loads).
REQ-027 in_ready SHALL equal !S1_valid || S1 advances; this combinational path from out_ready is permitted.
REQ-028 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-029 Line order SHALL be preserved.
REQ-030 When flush is high, both valids SHALL clear on the next edge, in_ready SHALL be 0 during that cycle, and drop_count SHALL be unchanged.
REQ-031 If flush and an input transfer coincide, the input line SHALL be discarded.
REQ-032 busy SHALL equal S1_valid || S2_valid.

Reset
REQ-033 While rst_l is low, the following SHALL be 0 immediately (asynchronously):
- out_valid, busy, drop_count;
- all out_* coordinate and intensity outputs;
- the S1 and S2 valid flags.
REQ-034 After reset release, in_ready SHALL be 1 in the first cycle.
REQ-035 Reset asserted mid-stream SHALL lose in-flight lines with no output of partial data.

Structure
REQ-036 Package bz_line_pkg SHALL hold:
- typedef line_t (four 13-bit signed endpoints plus 4-bit intensity);
- constants SCREEN_W=640, SCREEN_H=480, AVG_X_OFS=512, AVG_Y_OFS=384.
REQ-037 Sub-module line_map_coord SHALL implement one axis mapping (offset, ×5 via shift-add, >>>3, optional 479 reflection).
REQ-038 line_map_coord SHALL be instantiated four times, with no internal registers.

Verification
REQ-039 Input (0,0)→(511,383), intensity 7, out_ready=1: out (320,239)→(639,0), intensity 7, exactly 2 cycles later.
REQ-040 Input with intensity 0: out_valid never rises; drop_count goes 0→1.
REQ-041 Input start_x=end_x=-1000 (maps to -305): dropped; drop_count increments; the next valid line emerges unaffected.
REQ-042 Three back-to-back lines with out_ready=0 for 5 cycles: in_ready falls after 2 accepted lines; outputs hold; all 3 delivered in order once out_ready=1.
REQ-043 flush pulsed while both stages are full: no out_valid next cycle; drop_count unchanged. rst_l pulled low mid-stream: out_valid drops immediately and drop_count=0.
REQ-044 65,540 consecutive rejected lines: drop_count reaches and holds 0xFFFF.

Source files
------------

// File: rtl/bz_line_pkg.sv
// Shared types and screen constants for the AVG-to-screen line mapper.
package bz_line_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int AVG_X_OFS = 512;
    localparam int AVG_Y_OFS = 384;

    localparam logic signed [12:0] MAX_SX = 13'(SCREEN_W - 1);
    localparam logic signed [12:0] MAX_SY = 13'(SCREEN_H - 1);

    typedef struct packed {
        logic signed [12:0] start_x;
        logic signed [12:0] start_y;
        logic signed [12:0] end_x;
        logic signed [12:0] end_y;
        logic        [3:0]  intensity;
    } line_t;

    // A line is discarded when it is dark or lies wholly beyond one screen edge.
    function automatic logic line_rejected(input line_t l);
        return (l.intensity == 4'd0)
            || (l.start_x[12] && l.end_x[12])
            || ((l.start_x > MAX_SX) && (l.end_x > MAX_SX))
            || (l.start_y[12] && l.end_y[12])
            || ((l.start_y > MAX_SY) && (l.end_y > MAX_SY));
    endfunction

endpackage

// File: rtl/line_map_coord.sv
// One-axis AVG-to-screen mapping: (v + OFS) * 5 >>> 3, optionally mirrored.
module line_map_coord
    import bz_line_pkg::*;
#(
    parameter int OFS     = AVG_X_OFS,
    parameter bit REFLECT = 1'b0
) (
    input  logic signed [12:0] coord,
    output logic signed [12:0] mapped
);

    logic signed [15:0] biased;
    logic signed [15:0] scaled;
    logic signed [15:0] shifted;
    logic signed [15:0] refl;

    // Offset, x5 by shift-add, floor-divide by 8, then flip Y so row 0 is the top.
    always_comb begin
        biased  = {{3{coord[12]}}, coord} + 16'(OFS);
        scaled  = (biased <<< 2) + biased;
        shifted = scaled >>> 3;
        refl    = REFLECT ? (16'(SCREEN_H - 1) - shifted) : shifted;
        mapped  = 13'(refl);
    end

endmodule

// File: rtl/line_screen_mapper.sv
// Two-stage line mapper: S1 holds mapped endpoints, S2 is the output register.
// Off-screen or dark lines are dropped between S1 and S2 and counted.
module line_screen_mapper
    import bz_line_pkg::*;
(
    input  logic               clk,
    input  logic               rst_l,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [12:0] in_start_x,
    input  logic signed [12:0] in_start_y,
    input  logic signed [12:0] in_end_x,
    input  logic signed [12:0] in_end_y,
    input  logic        [3:0]  in_intensity,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [12:0] out_start_x,
    output logic signed [12:0] out_start_y,
    output logic signed [12:0] out_end_x,
    output logic signed [12:0] out_end_y,
    output logic        [3:0]  out_intensity,
    output logic        [15:0] drop_count,
    output logic               busy
);

    logic signed [12:0] m_sx, m_sy, m_ex, m_ey;
    line_t       map_line;
    line_t       s1_q, s1_d, s2_q, s2_d;
    logic        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [15:0] drop_q, drop_d;
    logic        s1_rej, s2_load, s1_adv, s1_pass, in_fire;

    line_map_coord #(.OFS(AVG_X_OFS), .REFLECT(1'b0)) u_map_sx (.coord(in_start_x), .mapped(m_sx));
    line_map_coord #(.OFS(AVG_Y_OFS), .REFLECT(1'b1)) u_map_sy (.coord(in_start_y), .mapped(m_sy));
    line_map_coord #(.OFS(AVG_X_OFS), .REFLECT(1'b0)) u_map_ex (.coord(in_end_x),   .mapped(m_ex));
    line_map_coord #(.OFS(AVG_Y_OFS), .REFLECT(1'b1)) u_map_ey (.coord(in_end_y),   .mapped(m_ey));

    // Handshake, stage advance and next-state for both stages and the drop counter.
    always_comb begin
        map_line = '{start_x: m_sx, start_y: m_sy, end_x: m_ex, end_y: m_ey,
                     intensity: in_intensity};

        s1_rej   = line_rejected(s1_q);
        s2_load  = !s2_vld_q || out_ready;
        s1_adv   = s1_vld_q && (s1_rej || s2_load);
        s1_pass  = s1_adv && !s1_rej;
        in_ready = !flush && (!s1_vld_q || s1_adv);
        in_fire  = in_valid && in_ready;

        s1_d     = s1_q;
        s1_vld_d = s1_vld_q;
        if (in_fire) begin
            s1_d     = map_line;
            s1_vld_d = 1'b1;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        s2_d     = s2_q;
        s2_vld_d = s2_vld_q;
        if (s2_load) begin
            s2_vld_d = s1_pass;
            if (s1_pass) s2_d = s1_q;
        end

        // A flush throws away everything in flight without counting it.
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end

        drop_d = drop_q;
        if (!flush && s1_adv && s1_rej && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
    end

    // Pipeline registers; reset clears valids, data and the counter.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            drop_q   <= drop_d;
        end
    end

    assign out_valid     = s2_vld_q;
    assign out_start_x   = s2_q.start_x;
    assign out_start_y   = s2_q.start_y;
    assign out_end_x     = s2_q.end_x;
    assign out_end_y     = s2_q.end_y;
    assign out_intensity = s2_q.intensity;
    assign drop_count    = drop_q;
    assign busy          = s1_vld_q || s2_vld_q;

endmodule

// File: tb/tb_line_screen_mapper.sv
// Randomized and directed bench for line_screen_mapper with a queue-based model.
module tb_line_screen_mapper;

    logic               clk = 1'b0;
    logic               rst_l = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [12:0] in_start_x = '0, in_start_y = '0, in_end_x = '0, in_end_y = '0;
    logic        [3:0]  in_intensity = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [12:0] out_start_x, out_start_y, out_end_x, out_end_y;
    logic        [3:0]  out_intensity;
    logic        [15:0] drop_count;
    logic               busy;

    line_screen_mapper dut (
        .clk(clk), .rst_l(rst_l), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_start_x(in_start_x), .in_start_y(in_start_y),
        .in_end_x(in_end_x), .in_end_y(in_end_y), .in_intensity(in_intensity),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_start_x(out_start_x), .out_start_y(out_start_y),
        .out_end_x(out_end_x), .out_end_y(out_end_y), .out_intensity(out_intensity),
        .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int sx; int sy; int ex; int ey; int inten; } mline_t;
    mline_t exp_q[$];
    int     drop_model = 0;
    bit     chk_en = 1'b0;

    function automatic int fdiv8(input int a);
        if (a >= 0) return a / 8;
        return -((-a + 7) / 8);
    endfunction

    function automatic int map_x(input int x);
        return fdiv8((x + 512) * 5);
    endfunction

    function automatic int map_y(input int y);
        return 479 - fdiv8((y + 384) * 5);
    endfunction

    function automatic bit visible(input mline_t m);
        if (m.inten == 0) return 0;
        if (m.sx < 0 && m.ex < 0) return 0;
        if (m.sx > 639 && m.ex > 639) return 0;
        if (m.sy < 0 && m.ey < 0) return 0;
        if (m.sy > 479 && m.ey > 479) return 0;
        return 1;
    endfunction

    // Per-cycle compare: outputs against the model queue, plus stall stability.
    bit                 prev_stall = 0, prev_flush = 0;
    logic signed [12:0] p_sx, p_sy, p_ex, p_ey;
    logic        [3:0]  p_in;
    always @(negedge clk) begin
        if (!rst_l || !chk_en) begin
            prev_stall = 0;
            prev_flush = 0;
        end else begin
            if (prev_stall && !prev_flush) check("hold_valid", out_valid, 1);
            if (prev_stall && out_valid) begin
                check("hold_sx", out_start_x, p_sx);
                check("hold_sy", out_start_y, p_sy);
                check("hold_ex", out_end_x, p_ex);
                check("hold_ey", out_end_y, p_ey);
                check("hold_int", out_intensity, p_in);
            end
            if (out_valid) begin
                check("busy_with_out", busy, 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got line (%0d,%0d) expected none",
                             out_start_x, out_start_y);
                end else begin
                    check("out_sx", out_start_x, exp_q[0].sx);
                    check("out_sy", out_start_y, exp_q[0].sy);
                    check("out_ex", out_end_x, exp_q[0].ex);
                    check("out_ey", out_end_y, exp_q[0].ey);
                    check("out_int", out_intensity, exp_q[0].inten);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                mline_t m;
                m.sx = map_x(in_start_x);
                m.sy = map_y(in_start_y);
                m.ex = map_x(in_end_x);
                m.ey = map_y(in_end_y);
                m.inten = in_intensity;
                if (visible(m)) exp_q.push_back(m);
                else if (drop_model < 65535) drop_model++;
            end
            prev_stall = out_valid && !out_ready;
            prev_flush = flush;
            p_sx = out_start_x; p_sy = out_start_y;
            p_ex = out_end_x;   p_ey = out_end_y; p_in = out_intensity;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int x0, input int y0, input int x1, input int y1,
                            input int i);
        in_start_x   = 13'(x0);
        in_start_y   = 13'(y0);
        in_end_x     = 13'(x1);
        in_end_y     = 13'(y1);
        in_intensity = 4'(i);
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1,
                        input int i);
        int n;
        set_line(x0, y0, x1, y1, i);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed %0d, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("drain_idle", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst_l is low.
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        check("rst_sx", out_start_x, 0);
        check("rst_int", out_intensity, 0);
        tick();
        tick();
        rst_l  = 1'b1;
        chk_en = 1'b1;
        check("first_in_ready", in_ready, 1);

        // Basic mapping and two-cycle latency.
        set_line(0, 0, 511, 383, 7);
        in_valid = 1'b1;
        check("t1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t1_valid_c1", out_valid, 0);
        tick();
        check("t1_valid_c2", out_valid, 1);
        check("t1_sx", out_start_x, 320);
        check("t1_sy", out_start_y, 239);
        check("t1_ex", out_end_x, 639);
        check("t1_ey", out_end_y, 0);
        check("t1_int", out_intensity, 7);
        drain();

        // Dark line is dropped.
        send(100, 100, 200, 200, 0);
        drain();
        check("t2_drop", drop_count, 1);

        // Wholly left of screen, followed by a normal line.
        send(-1000, 0, -1000, 100, 5);
        send(10, 20, 30, 40, 9);
        drain();
        check("t3_drop", drop_count, 2);

        // Back-pressure: two lines fill the pipe, third waits.
        out_ready = 1'b0;
        send(0, 0, 0, 0, 1);
        send(8, 8, 8, 8, 2);
        set_line(16, 16, 16, 16, 3);
        in_valid = 1'b1;
        check("t4_in_ready_full", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_sx", out_start_x, 320);
            check("t4_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send(16, 16, 16, 16, 3);
        drain();

        // Flush with both stages full; a coinciding input is discarded.
        out_ready = 1'b0;
        send(1, 1, 1, 1, 4);
        send(2, 2, 2, 2, 5);
        set_line(3, 3, 3, 3, 6);
        in_valid = 1'b1;
        flush    = 1'b1;
        check("t5_flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_flush_out_valid", out_valid, 0);
        check("t5_flush_busy", busy, 0);
        check("t5_flush_drop", drop_count, 2);
        out_ready = 1'b1;
        send(4, 4, 4, 4, 8);
        drain();

        // Reset mid-stream.
        out_ready = 1'b0;
        send(5, 5, 5, 5, 1);
        send(6, 6, 6, 6, 2);
        chk_en = 1'b0;
        #1;
        rst_l = 1'b0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_drop", drop_count, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_sx", out_start_x, 0);
        exp_q.delete();
        drop_model = 0;
        tick();
        rst_l     = 1'b1;
        out_ready = 1'b1;
        chk_en    = 1'b1;
        check("t6_in_ready_after", in_ready, 1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int x0, y0, x1, y1;
            if ($urandom_range(0, 1) == 1) begin
                x0 = int'($urandom_range(0, 2400)) - 1200;
                x1 = int'($urandom_range(0, 2400)) - 1200;
                y0 = int'($urandom_range(0, 2000)) - 1000;
                y1 = int'($urandom_range(0, 2000)) - 1000;
            end else begin
                x0 = int'($urandom_range(0, 8191)) - 4096;
                x1 = int'($urandom_range(0, 8191)) - 4096;
                y0 = int'($urandom_range(0, 8191)) - 4096;
                y1 = int'($urandom_range(0, 8191)) - 4096;
            end
            set_line(x0, y0, x1, y1, int'($urandom_range(0, 15)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("rand_drop", drop_count, drop_model);
        check("rand_queue_empty", exp_q.size(), 0);

        // Saturation of the drop counter.
        set_line(0, 0, 10, 10, 0);
        in_valid = 1'b1;
        for (int c = 0; c < 65540; c++) tick();
        in_valid = 1'b0;
        drain();
        check("sat_drop", drop_count, 16'hFFFF);
        send(0, 0, 10, 10, 0);
        send(-2000, 0, -2000, 0, 3);
        drain();
        check("sat_hold", drop_count, 16'hFFFF);
        check("sat_model", drop_count, drop_model);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
